// File: rtl/opseq_pkg.sv
// Shared types and constants for the operand fetch sequencer.
package opseq_pkg;

    // Accumulator slot count; bounds the per-command operand count.
    localparam int unsigned MAX_OPS = 3;
    localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        FLUSH,
        WAIT_DONE
    } opseq_state_t;

endpackage

// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: streams 1..MAX_OPS bytes from sync-read memory into the
// 3-slot accumulator, issues one put-low flush cycle, then waits for the accumulator's done.
// Optional feature macro: OPSEQ_RANGE_CHECK_EN (reject count==0 / address overrun with err).
module operand_fetch_sequencer
    import opseq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              finished,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              acc_put,
    output logic [DATA_W-1:0] acc_value,
    input  logic              acc_done
);

    opseq_state_t      r_state, w_state_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic [CNT_W-1:0]  r_rem, w_rem_d;
    logic              r_rd_valid;
    logic              w_range_bad;

`ifdef OPSEQ_RANGE_CHECK_EN
    logic [ADDR_W:0] w_last;
    logic            r_err;

    // One extra bit catches a last address that runs past the top of memory.
    assign w_last      = {1'b0, base_addr} + (ADDR_W + 1)'(count) - (ADDR_W + 1)'(1);
    assign w_range_bad = (count == '0) || w_last[ADDR_W];

    // Error pulse lands one cycle after the rejected start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && start && w_range_bad;
        end
    end

    assign err = r_err;
`else
    assign w_range_bad = 1'b0;
    assign err         = 1'b0;
`endif

    // State, address and remaining-count registers plus read-valid delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_addr     <= w_addr_d;
            r_rem      <= w_rem_d;
            r_rd_valid <= mem_rd_en;
        end
    end

    // Next-state and counter update.
    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_rem_d   = r_rem;
        unique case (r_state)
            IDLE: begin
                if (start && !w_range_bad) begin
                    w_addr_d  = base_addr;
                    w_rem_d   = count;
                    // A zero-count command still flushes so the accumulator publishes.
                    w_state_d = (count == '0) ? FLUSH : FETCH;
                end
            end
            FETCH: begin
                w_addr_d = r_addr + ADDR_W'(1);
                w_rem_d  = r_rem - CNT_W'(1);
                if (r_rem == CNT_W'(1)) begin
                    w_state_d = DRAIN;
                end
            end
            DRAIN:     w_state_d = FLUSH;
            FLUSH:     w_state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (acc_done) begin
                    w_state_d = IDLE;
                end
            end
            default:   w_state_d = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign mem_rd_en = (r_state == FETCH);
    assign mem_addr  = mem_rd_en ? r_addr : '0;
    // Read data arrives one cycle after the request, so the put strobe trails the read.
    assign acc_put   = r_rd_valid;
    assign acc_value = mem_rdata;
    assign finished  = (r_state == WAIT_DONE) && acc_done;

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed bench for operand_fetch_sequencer with a sync-read memory model.
module tb_operand_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [1:0] count;
    logic       busy, finished, err, mem_rd_en, acc_put;
    logic [7:0] mem_addr, acc_value;
    logic [7:0] mem_rdata = 8'h00;
    logic       acc_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // Sync-read memory: data valid one cycle after the request.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    operand_fetch_sequencer #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .finished  (finished),
        .err       (err),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .acc_put   (acc_put),
        .acc_value (acc_value),
        .acc_done  (acc_done)
    );

    task automatic chk(input string tag, input string sig, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, sig, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic rd, input logic [7:0] addr,
                       input logic put, input logic [7:0] val, input logic fin,
                       input logic bsy, input logic er);
        @(negedge clk);
        chk(tag, "busy", {31'd0, busy}, {31'd0, bsy});
        chk(tag, "mem_rd_en", {31'd0, mem_rd_en}, {31'd0, rd});
        if (rd) chk(tag, "mem_addr", {24'd0, mem_addr}, {24'd0, addr});
        chk(tag, "acc_put", {31'd0, acc_put}, {31'd0, put});
        if (put) chk(tag, "acc_value", {24'd0, acc_value}, {24'd0, val});
        chk(tag, "finished", {31'd0, finished}, {31'd0, fin});
        chk(tag, "err", {31'd0, err}, {31'd0, er});
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
        mem[8'h40] = 8'h5D;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22;
        mem[8'hFF] = 8'hEE; mem[8'h00] = 8'h01;

        reset = 1'b1; start = 1'b0; base_addr = 8'h00; count = 2'd0; acc_done = 1'b1;

        // Reset values
        @(negedge clk);
        chk("reset", "mem_addr", {24'd0, mem_addr}, 32'd0);
        cyc("reset", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        reset = 1'b0;
        cyc("idle", 0, 8'h00, 0, 8'h00, 0, 0, 0);

        // A: base 0x10, count 3, acc_done already high
        start = 1'b1; base_addr = 8'h10; count = 2'd3;
        cyc("A.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
        cyc("A.S1", 1, 8'h10, 0, 8'h00, 0, 1, 0);
        cyc("A.S2", 1, 8'h11, 1, 8'hA1, 0, 1, 0);
        cyc("A.S3", 1, 8'h12, 1, 8'hB2, 0, 1, 0);
        cyc("A.S4", 0, 8'h00, 1, 8'hC3, 0, 1, 0);
        cyc("A.S5", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        cyc("A.S6", 0, 8'h00, 0, 8'h00, 1, 1, 0);
        cyc("A.S7", 0, 8'h00, 0, 8'h00, 0, 0, 0);

        // B: count 1, acc_done held low until S+8
        acc_done = 1'b0;
        start = 1'b1; base_addr = 8'h40; count = 2'd1;
        cyc("B.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
        cyc("B.S1", 1, 8'h40, 0, 8'h00, 0, 1, 0);
        cyc("B.S2", 0, 8'h00, 1, 8'h5D, 0, 1, 0);
        cyc("B.S3", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        for (int k = 4; k < 8; k++) cyc("B.wait", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        acc_done = 1'b1;
        cyc("B.S8", 0, 8'h00, 0, 8'h00, 1, 1, 0);
        cyc("B.S9", 0, 8'h00, 0, 8'h00, 0, 0, 0);

        // C: count 2 with a stray start mid-run and another on the finished cycle
        start = 1'b1; base_addr = 8'h20; count = 2'd2;
        cyc("C.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
        cyc("C.S1", 1, 8'h20, 0, 8'h00, 0, 1, 0);
        start = 1'b1; base_addr = 8'h30; count = 2'd3;
        cyc("C.S2", 1, 8'h21, 1, 8'h11, 0, 1, 0);
        start = 1'b0;
        cyc("C.S3", 0, 8'h00, 1, 8'h22, 0, 1, 0);
        cyc("C.S4", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        start = 1'b1;
        cyc("C.S5", 0, 8'h00, 0, 8'h00, 1, 1, 0);
        start = 1'b0;
        cyc("C.S6", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        cyc("C.S7", 0, 8'h00, 0, 8'h00, 0, 0, 0);

        // D: reset at S+3 of a count 3 run, then a normal count 1 run
        start = 1'b1; base_addr = 8'h10; count = 2'd3;
        cyc("D.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
        cyc("D.S1", 1, 8'h10, 0, 8'h00, 0, 1, 0);
        cyc("D.S2", 1, 8'h11, 1, 8'hA1, 0, 1, 0);
        reset = 1'b1;
        cyc("D.rst", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        reset = 1'b0;
        cyc("D.idle", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b1; base_addr = 8'h40; count = 2'd1;
        cyc("D2.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
        cyc("D2.S1", 1, 8'h40, 0, 8'h00, 0, 1, 0);
        cyc("D2.S2", 0, 8'h00, 1, 8'h5D, 0, 1, 0);
        cyc("D2.S3", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        cyc("D2.S4", 0, 8'h00, 0, 8'h00, 1, 1, 0);
        cyc("D2.S5", 0, 8'h00, 0, 8'h00, 0, 0, 0);

        // E: base 0xFF, count 2
        start = 1'b1; base_addr = 8'hFF; count = 2'd2;
        cyc("E.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
`ifdef OPSEQ_RANGE_CHECK_EN
        cyc("E.S1", 0, 8'h00, 0, 8'h00, 0, 0, 1);
        cyc("E.S2", 0, 8'h00, 0, 8'h00, 0, 0, 0);
`else
        cyc("E.S1", 1, 8'hFF, 0, 8'h00, 0, 1, 0);
        cyc("E.S2", 1, 8'h00, 1, 8'hEE, 0, 1, 0);
        cyc("E.S3", 0, 8'h00, 1, 8'h01, 0, 1, 0);
        cyc("E.S4", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        cyc("E.S5", 0, 8'h00, 0, 8'h00, 1, 1, 0);
        cyc("E.S6", 0, 8'h00, 0, 8'h00, 0, 0, 0);
`endif

        // F: count 0
        start = 1'b1; base_addr = 8'h50; count = 2'd0;
        cyc("F.S", 0, 8'h00, 0, 8'h00, 0, 0, 0);
        start = 1'b0;
`ifdef OPSEQ_RANGE_CHECK_EN
        cyc("F.S1", 0, 8'h00, 0, 8'h00, 0, 0, 1);
        cyc("F.S2", 0, 8'h00, 0, 8'h00, 0, 0, 0);
`else
        cyc("F.S1", 0, 8'h00, 0, 8'h00, 0, 1, 0);
        cyc("F.S2", 0, 8'h00, 0, 8'h00, 1, 1, 0);
        cyc("F.S3", 0, 8'h00, 0, 8'h00, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
